// File: rtl/ct_pt_add_seq.sv
// ct_pt_add_seq: slot-serial ciphertext-plaintext adder CT' = (A mod Q, (B + DELTA*gamma) mod Q)
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_ct/in_gamma input handshake;
// out_valid/out_ready/out_ct registered result handshake; busy = PROC or DONE.
// in_ct/out_ct are packed as [1]=B vector, [0]=A vector, each [N-1:0][W-1:0].
// Optional macro CT_PT_ADD_SEQ_STATS_EN adds op_count, a wrapping count of output handshakes.
`ifndef N_SLOTS
`define N_SLOTS 8
`endif
`ifndef W_BITS
`define W_BITS 16
`endif
`ifndef Q_MOD
`define Q_MOD 7710
`endif
`ifndef DELTA
`define DELTA 30
`endif
module ct_pt_add_seq #(
  parameter int unsigned N = `N_SLOTS,
  parameter int unsigned W = `W_BITS,
  parameter int unsigned Q = `Q_MOD,
  parameter int unsigned DELTA = `DELTA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0][N-1:0][W-1:0] in_ct,
  input  logic [N-1:0][W-1:0]      in_gamma,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0][N-1:0][W-1:0] out_ct,
  output logic                     busy
`ifdef CT_PT_ADD_SEQ_STATS_EN
  ,
  output logic [31:0]              op_count
`endif
);
  localparam int unsigned IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [1:0][N-1:0][W-1:0] ct_q;
  logic [N-1:0][W-1:0] gamma_q;
  logic [2*W-1:0] prod;
  logic [2*W:0] sum;
  logic [W-1:0] a_mod, b_mod;
  logic last, in_hs, out_hs;
  always_comb begin
    in_ready = state == IDLE && !rst;
    out_valid = state == DONE;
    busy = state == PROC || state == DONE;
    in_hs = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    last = idx == IW'(N - 1);
    state_nx = state == IDLE ? (in_hs ? PROC : IDLE) :
               state == PROC ? (last ? DONE : PROC) :
               state == DONE ? (out_hs ? IDLE : DONE) : IDLE;
  end
  // Full-width product and sum so the reduction is exact for any W-bit operands.
  always_comb begin
    prod = (2*W)'(DELTA) * (2*W)'(gamma_q[idx]);
    sum = (2*W+1)'(ct_q[1][idx]) + (2*W+1)'(prod);
    a_mod = W'(ct_q[0][idx] % W'(Q));
    b_mod = W'(sum % (2*W+1)'(Q));
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (in_hs) begin
      ct_q <= in_ct;
      gamma_q <= in_gamma;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      out_ct <= '0;
    end else if (in_hs) begin
      idx <= '0;
    end else if (state == PROC) begin
      out_ct[0][idx] <= a_mod;
      out_ct[1][idx] <= b_mod;
      idx <= last ? '0 : idx + IW'(1);
    end
  end
`ifdef CT_PT_ADD_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) op_count <= '0;
    else if (out_hs) op_count <= op_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ct_pt_add_seq.sv
// tb_ct_pt_add_seq: scoreboard bench for ct_pt_add_seq with directed hand-computed vectors
module tb_ct_pt_add_seq;
  typedef logic [7:0][15:0] pt_t;
  typedef logic [1:0][7:0][15:0] ct_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  ct_t in_ct = '0, out_ct;
  pt_t in_gamma = '0;
`ifdef CT_PT_ADD_SEQ_STATS_EN
  logic [31:0] op_count;
`endif
  ct_t_dummy_guard: assert property (@(posedge clk) 1'b1);
  ct_pt_add_seq #(.N(8), .W(16), .Q(7710), .DELTA(30)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ct(in_ct), .in_gamma(in_gamma), .out_valid(out_valid),
    .out_ready(out_ready), .out_ct(out_ct), .busy(busy)
`ifdef CT_PT_ADD_SEQ_STATS_EN
    , .op_count(op_count)
`endif
  );
  always #5 clk = ~clk;
  int asserts = 0, fails = 0, cyc = 0;
  int last_cap = -100, last_out_hs = -100;
  int caps[$];
  ct_t exp_q[$];
  ct_t held;
  bit ov_prev = 0;
  ct_t c1, c2, c3, c4, e1, e2, e3, e4;
  pt_t g1, g2, g3, g4;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic pt_t v(input int x0, x1, x2, x3, x4, x5, x6, x7);
    v = {16'(x7), 16'(x6), 16'(x5), 16'(x4), 16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction
  function automatic ct_t mk(input pt_t a, input pt_t b);
    mk = {b, a};
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: edges are numbered by cyc; a handshake seen at a negedge lands on edge cyc+1.
  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      caps.push_back(cyc + 1);
      last_cap = cyc + 1;
    end
    if (out_valid && !ov_prev) chk("latency", 256'(cyc - last_cap), 256'(8));
    if (out_valid && ov_prev) chk("hold_stable", 256'(out_ct), 256'(held));
    if (out_valid) chk("in_ready_low_in_done", 256'(in_ready), 256'(0));
    if (out_valid && out_ready) begin
      last_out_hs = cyc + 1;
      if (exp_q.size() == 0) chk("unexpected_output", 256'(1), 256'(0));
      else chk("result", 256'(out_ct), 256'(exp_q.pop_front()));
    end
    held = out_ct;
    ov_prev = out_valid;
  end
  task automatic send(input ct_t ct, input pt_t g, input ct_t exp, input bit push);
    bit done = 0;
    if (push) exp_q.push_back(exp);
    in_ct = ct;
    in_gamma = g;
    in_valid = 1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 0;
    if (!done) chk("send_timeout", 256'(0), 256'(1));
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", 256'(exp_q.size()), 256'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    c1 = mk(v(1429, 4717, 6311, 3279, 7215, 6215, 6931, 973), v(7531, 4381, 1094, 7529, 5909, 964, 5576, 4640));
    g1 = v(1, 2, 3, 4, 5, 6, 7, 8);
    e1 = mk(v(1429, 4717, 6311, 3279, 7215, 6215, 6931, 973), v(7561, 4441, 1184, 7649, 6059, 1144, 5786, 4880));
    c2 = mk(v(7715, 0, 0, 0, 0, 0, 0, 0), v(7700, 7709, 0, 0, 0, 0, 0, 0));
    g2 = v(1, 256, 0, 0, 0, 0, 0, 0);
    e2 = mk(v(5, 0, 0, 0, 0, 0, 0, 0), v(20, 7679, 0, 0, 0, 0, 0, 0));
    c3 = mk(v(7710, 7711, 15420, 65535, 0, 100, 7709, 20000), v(0, 7709, 7708, 100, 0, 0, 0, 65535));
    g3 = v(257, 1, 2, 0, 0, 0, 0, 65535);
    e3 = mk(v(0, 1, 0, 3855, 0, 100, 7709, 4580), v(0, 29, 58, 100, 0, 0, 0, 3855));
    c4 = mk(v(1, 2, 3, 4, 5, 6, 7, 8), v(10, 20, 30, 40, 50, 60, 70, 80));
    g4 = v(8, 7, 6, 5, 4, 3, 2, 1);
    e4 = mk(v(1, 2, 3, 4, 5, 6, 7, 8), v(250, 230, 210, 190, 170, 150, 130, 110));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_out_ct", 256'(out_ct), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;
    send(c1, g1, e1, 1);
    drain();
    send(c2, g2, e2, 1);
    drain();
    out_ready = 0;
    n = caps.size();
    send(c3, g3, e3, 1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid", 256'(out_valid), 256'(1));
    repeat (20) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_ct = c4;
      in_gamma = g4;
    end
    chk("bp_no_capture", 256'(caps.size()), 256'(n + 1));
    out_ready = 1;
    send(c4, g4, e4, 1);
    chk("bp_capture_after_hs", 256'(caps[caps.size()-1]), 256'(last_out_hs + 1));
    drain();
    n = caps.size();
    send(c1, g1, e1, 1);
    send(c2, g2, e2, 1);
    send(c3, g3, e3, 1);
    drain();
    if (caps.size() >= n + 3) begin
      chk("b2b_spacing_1", 256'(caps[n+1] - caps[n]), 256'(10));
      chk("b2b_spacing_2", 256'(caps[n+2] - caps[n+1]), 256'(10));
    end else chk("b2b_captures", 256'(caps.size()), 256'(n + 3));
    send(c1, g1, e1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 256'(busy), 256'(1));
    rst = 1;
    #1;
    chk("mid_in_ready_in_rst", 256'(in_ready), 256'(0));
    @(posedge clk);
    #1;
    rst = 0;
    chk("mid_out_valid", 256'(out_valid), 256'(0));
    chk("mid_out_ct", 256'(out_ct), 256'(0));
    chk("mid_busy_clear", 256'(busy), 256'(0));
    @(negedge clk);
    chk("mid_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;
    send(c4, g4, e4, 1);
    drain();
`ifdef CT_PT_ADD_SEQ_STATS_EN
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (5) send(c4, g4, e4, 1);
    drain();
    chk("stats_five", 256'(op_count), 256'(5));
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("stats_reset", 256'(op_count), 256'(0));
    send(c2, g2, e2, 1);
    drain();
    chk("stats_one", 256'(op_count), 256'(1));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/ct_pt_add_seq.md
# ct_pt_add_seq

Slot-serial sequencer for the ciphertext–plaintext addition `CT' = (A mod q, (B + Δ·Γ) mod q)`. It accepts one `CT_t`/`PT_t` pair through a valid/ready handshake and walks the `N` slots one per cycle through a single shared scale-and-reduce lane. It holds the finished `CT_t` until the consumer accepts it. It sits between the ciphertext load path and any downstream homomorphic stage, and replaces the fully parallel N-lane adder where area matters.

## Interface
Parameters:
- `N`, `` `N_SLOTS ``: number of slots per vector.
- `W`, `` `W_BITS ``: bits per slot coefficient.
- `Q`, `` `Q_MOD ``: ciphertext modulus q.
- `DELTA`, `` `DELTA ``: scaling factor Δ.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: `in_ct` and `in_gamma` are valid.
- `in_ready`, out, 1: block can accept an operand pair.
- `in_ct`, in, `CT_t`: input ciphertext (A, B vectors, N×W).
- `in_gamma`, in, `PT_t`: plaintext vector Γ (N×W).
- `out_valid`, out, 1: `out_ct` holds a completed result.
- `out_ready`, in, 1: consumer accepts the result.
- `out_ct`, out, `CT_t`: result ciphertext, registered.
- `busy`, out, 1: high when the state is PROC or DONE.

## Operation
- The FSM has three states: IDLE, PROC and DONE. A slot index register `idx` has width `$clog2(N)`.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `in_ct` and `in_gamma` into internal registers, set `idx` = 0 and go to PROC.
- **PROC**
  - Each cycle, write `out_ct.A[idx] = A[idx] mod Q`.
  - In the same cycle, write `out_ct.B[idx] = (B[idx] + DELTA·Γ[idx]) mod Q`.
  - Then increment `idx`. On `idx == N-1`, go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `out_ct` is stable until `out_valid & out_ready`, then go to IDLE.
- Arithmetic:
  - The product `DELTA·Γ` is computed at 2W bits.
  - The sum with B is computed at 2W+1 bits, then reduced by exact `mod Q`. There is no truncation before the reduction.
  - Results are always in [0, Q-1], including inputs ≥ Q.
- Only the latched copies are used during PROC. Input ports may change freely once the input handshake has completed.
- `in_ready` is low in PROC and DONE. `in_valid` asserted there is ignored; there is no queueing.
- `out_ready` is ignored outside DONE.
- Slots of `out_ct` not yet written in PROC keep their previous values. They are only observable as meaningful once `out_valid` = 1.

## Timing
- Reset values:
  - State IDLE, `idx` = 0.
  - `out_ct` = all zero (A and B).
  - `out_valid` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` deasserts.
- The input handshake occurs at edge E.
  - Slots 0..N-1 are written at edges E+1..E+N.
  - `out_valid` rises after edge E+N.
- Output handshake at edge F: `out_valid` drops and `in_ready` rises after F. The next capture can occur at edge F+1.
- Sustained throughput with `out_ready` tied high is one operation per N+2 cycles.
- Reset asserted mid-PROC or in DONE:
  - The operation is abandoned. There is no partial output handshake.
  - Outputs return to their reset values after that edge.
- `out_valid` never deasserts without an output handshake, except on reset.

## Configuration
- Macro `` `CT_PT_ADD_SEQ_STATS_EN ``.
- **Defined:**
  - Adds output port `op_count` (out, 32 bits).
  - `op_count` is reset to 0 by `rst` and increments by 1 on each output handshake (`out_valid & out_ready`).
  - It wraps from 2^32-1 to 0.
- **Undefined:** the port and counter do not exist. The rest of the behaviour is identical.

## Test plan
Parameters for all scenarios: Q=7710, Δ=30, N=8, W=16.
- **Fixed vector**
  - Stimulus:
    - A = [1429,4717,6311,3279,7215,6215,6931,973]
    - B = [7531,4381,1184→ see below]; in full, B = [7531,4381,1094,7529,5909,964,5576,4640]
    - Γ = [1..8]
  - Required response:
    - `out_valid` exactly 8 cycles after the capture edge.
    - A unchanged.
    - B = [7561,4441,1184,7649,6059,1144,5786,4880].
- **Wrap and reduction**
  - Stimulus: A[0]=7715, B[0]=7700, Γ[0]=1, and B[1]=7709, Γ[1]=256.
  - Required response: A[0]=5, B[0]=20, B[1]=7679.
- **Backpressure**
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid` rises, and toggle `in_valid` with new data during that time.
  - Required response:
    - `out_ct` is stable and `in_ready` stays 0.
    - The second operand pair is not captured until one cycle after the handshake.
    - Its result is correct.
- **Back-to-back**
  - Stimulus: `out_ready` tied 1, three operand pairs offered continuously.
  - Required response: captures spaced 10 cycles apart, three correct results in order.
- **Mid-operation reset**
  - Stimulus: assert `rst` for 1 cycle at PROC slot 4.
  - Required response:
    - `out_valid`=0 and `out_ct`=0 after the reset edge.
    - `in_ready`=1 on the next cycle.
    - A fresh operation then completes correctly.
- **STATS_EN**
  - Stimulus: with `` `CT_PT_ADD_SEQ_STATS_EN ``, run 5 operations, reset, then run 1.
  - Required response: `op_count` = 5, then 0, then 1.
